tt_aes_lite_decrypt: RTL and testbench

//   Inverse of the AES-lite byte encryptor: recovers a plaintext byte from a ciphertext byte and key.

---
 rtl/tt_aes_lite_decrypt.sv | 97 +++++++++
 tb/tb_tt_aes_lite_decrypt.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/tt_aes_lite_decrypt.sv
// AES-lite byte decryptor: undoes the encryptor's XOR rounds by running them in
// reverse round-constant order, then holds the plaintext under a valid/ack handshake.
module tt_aes_lite_decrypt #(
    parameter int DATA_W     = 8,
    parameter int NUM_ROUNDS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    input  logic              out_ack,
    output logic              busy,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid
);

    // The round constant only needs to reach NUM_ROUNDS-1; keep at least one bit.
    localparam int RC_W = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [RC_W-1:0]   rc;
    logic [DATA_W-1:0] state_reg;
    logic [DATA_W-1:0] key_reg;

    // Zero-extend or truncate the round constant onto the data width.
    function automatic logic [DATA_W-1:0] rc_to_data(input logic [RC_W-1:0] rc_v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) begin
            if (i < RC_W) begin
                r[i] = rc_v[i];
            end
        end
        return r;
    endfunction

    // Single controller: FSM, round datapath and handshake outputs, all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rc        <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Consumer acknowledge; later assignments (new start, DONE) take priority.
            if (out_ack && out_valid) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_reg <= data_in;
                        key_reg   <= key_in;
                        rc        <= RC_LAST;
                        out_valid <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_ROUND;
                    end
                end

                S_ROUND: begin
                    state_reg <= state_reg ^ key_reg ^ rc_to_data(rc);
                    if (rc != '0) begin
                        rc <= rc - RC_W'(1);
                    end else begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    data_out  <= state_reg;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_aes_lite_decrypt.sv
// Directed bench for tt_aes_lite_decrypt: a 10-round and a 3-round instance share
// clock and reset; table vectors plus hand-written handshake/reset sequences.
module tb_tt_aes_lite_decrypt;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b, ack_a, ack_b;
    logic [7:0] din_a, key_a, din_b, key_b;
    logic       busy_a, busy_b, vld_a, vld_b;
    logic [7:0] dout_a, dout_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tt_aes_lite_decrypt #(.DATA_W(8), .NUM_ROUNDS(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .data_in(din_a), .key_in(key_a),
        .out_ack(ack_a), .busy(busy_a), .data_out(dout_a), .out_valid(vld_a)
    );

    tt_aes_lite_decrypt #(.DATA_W(8), .NUM_ROUNDS(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .data_in(din_b), .key_in(key_b),
        .out_ack(ack_b), .busy(busy_b), .data_out(dout_b), .out_valid(vld_b)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] key;
        logic [7:0] exp;
    } vec_t;

    vec_t vec_a[5];
    vec_t vec_b[3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Encryptor reference: rounds with round constant counting up from 0.
    function automatic logic [7:0] enc(input logic [7:0] d, input logic [7:0] k, input int nr);
        logic [7:0] s;
        s = d;
        for (int r = 0; r < nr; r++) s = s ^ k ^ 8'(r);
        return s;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic ak,
                         input logic [7:0] d, input logic [7:0] k);
        if (sel) begin
            start_b = st; ack_b = ak; din_b = d; key_b = k;
        end else begin
            start_a = st; ack_a = ak; din_a = d; key_a = k;
        end
    endtask

    // One operation: latency, busy duration and result. glitch raises start mid-ROUND;
    // ack_too raises out_ack together with start.
    task automatic run_op(input bit sel, input logic [7:0] d, input logic [7:0] k,
                          input logic [7:0] exp, input string nm,
                          input bit glitch, input bit ack_too);
        int nr, n, busy_cnt;
        bit got;
        nr = sel ? 3 : 10;
        drive(sel, 1'b1, ack_too, d, k);
        step();
        drive(sel, 1'b0, 1'b0, ~d, ~k);
        if (ack_too) begin
            chk({nm, "_startack_vld"}, 32'(sel ? vld_b : vld_a), 32'd0);
            chk({nm, "_startack_busy"}, 32'(sel ? busy_b : busy_a), 32'd1);
        end
        busy_cnt = (sel ? busy_b : busy_a) ? 1 : 0;
        n = 0;
        got = 0;
        while (n < 40 && !got) begin
            if (glitch && n == 2) drive(sel, 1'b1, 1'b0, 8'hFF, 8'hFF);
            if (glitch && n == 4) drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
            step();
            n++;
            if (sel ? vld_b : vld_a) got = 1;
            else if (sel ? busy_b : busy_a) busy_cnt++;
        end
        chk({nm, "_latency"}, 32'(n), 32'(nr + 1));
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(nr + 1));
        chk({nm, "_busy_after"}, 32'(sel ? busy_b : busy_a), 32'd0);
        chk({nm, "_data"}, 32'(sel ? dout_b : dout_a), 32'(exp));
    endtask

    task automatic do_ack(input bit sel, input logic [7:0] exp, input string nm);
        drive(sel, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        drive(sel, 1'b0, 1'b0, 8'h00, 8'h00);
        chk({nm, "_ack_vld"}, 32'(sel ? vld_b : vld_a), 32'd0);
        chk({nm, "_ack_data_held"}, 32'(sel ? dout_b : dout_a), 32'(exp));
    endtask

    initial begin
        vec_a[0] = '{din: 8'h3D, key: 8'hA5, exp: 8'h3C};
        vec_a[1] = '{din: 8'h00, key: 8'h00, exp: 8'h01};
        vec_a[2] = '{din: 8'hFF, key: 8'h12, exp: 8'hFE};
        vec_a[3] = '{din: 8'h80, key: 8'hFF, exp: 8'h81};
        vec_a[4] = '{din: 8'h55, key: 8'h7C, exp: 8'h54};
        vec_b[0] = '{din: 8'h00, key: 8'h5A, exp: 8'h59};
        vec_b[1] = '{din: 8'hFF, key: 8'h00, exp: 8'hFC};
        vec_b[2] = '{din: 8'h12, key: 8'h34, exp: 8'h25};

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
        step();
        step();
        chk("rst_data_a", 32'(dout_a), 32'd0);
        chk("rst_vld_a", 32'(vld_a), 32'd0);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_data_b", 32'(dout_b), 32'd0);
        chk("rst_vld_b", 32'(vld_b), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst = 1'b0;
        step();

        // Ack while nothing is valid has no effect.
        drive(0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("idle_ack_vld", 32'(vld_a), 32'd0);
        chk("idle_ack_busy", 32'(busy_a), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_op(0, vec_a[i].din, vec_a[i].key, vec_a[i].exp, $sformatf("vecA%0d", i), 0, 0);
            do_ack(0, vec_a[i].exp, $sformatf("vecA%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            run_op(1, vec_b[i].din, vec_b[i].key, vec_b[i].exp, $sformatf("vecB%0d", i), 0, 0);
            do_ack(1, vec_b[i].exp, $sformatf("vecB%0d", i));
        end

        // Round trip through the encryptor; result held until acknowledged.
        run_op(0, enc(8'h7E, 8'h13, 10), 8'h13, 8'h7E, "roundtrip", 0, 0);
        repeat (5) step();
        chk("roundtrip_hold_vld", 32'(vld_a), 32'd1);
        chk("roundtrip_hold_data", 32'(dout_a), 32'h7E);
        do_ack(0, 8'h7E, "roundtrip");

        // start during ROUND ignored, then start+ack in the same IDLE cycle.
        run_op(0, 8'h3D, 8'hA5, 8'h3C, "ignored_start", 1, 0);
        run_op(0, 8'h00, 8'h00, 8'h01, "start_ack", 0, 1);

        // Reset in the middle of the rounds discards the operation.
        drive(0, 1'b1, 1'b0, 8'h3D, 8'hA5);
        step();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vld", 32'(vld_a), 32'd0);
        chk("midrst_data", 32'(dout_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd0);
        repeat (12) step();
        chk("midrst_stays_idle_vld", 32'(vld_a), 32'd0);
        chk("midrst_stays_idle_busy", 32'(busy_a), 32'd0);
        run_op(0, 8'h3D, 8'hA5, 8'h3C, "after_rst", 0, 0);

        // Ack present on the DONE edge: valid still set, cleared on the following edge.
        drive(0, 1'b1, 1'b0, 8'h11, 8'h22);
        step();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (10) step();
        drive(0, 1'b0, 1'b1, 8'h00, 8'h00);
        step();
        chk("ack_on_done_vld", 32'(vld_a), 32'd1);
        chk("ack_on_done_data", 32'(dout_a), 32'h10);
        step();
        drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
        chk("ack_after_done_vld", 32'(vld_a), 32'd0);
        chk("ack_after_done_data", 32'(dout_a), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
